// File: rtl/tx_lane_serializer.sv
// rtl/tx_lane_serializer.sv - parallel-to-serial lane stage for encoded flits with one-entry hold
module tx_lane_serializer #(
  parameter int NSYM  = 4,
  parameter int LANES = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [NSYM*10-1:0]    i_enc_flit,
  input  logic                  i_start,
  input  logic [1:0]            i_comma_length_sel,
  output logic [LANES-1:0]      o_serial_out,
  output logic                  o_serial_valid,
  output logic                  o_done,
  output logic                  o_ready,
  output logic                  o_busy,
  output logic                  o_overrun
);

  localparam int FW   = NSYM * 10;
  localparam int BMAX = FW / LANES;
  localparam int CW   = $clog2(BMAX + 1);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_SHIFT = 1'b1;

  // Beats needed for a flit of the selected length; 11 falls back to full length.
  function automatic logic [CW-1:0] f_beats(input logic [1:0] sel);
    case (sel)
      2'b01:   f_beats = CW'(10 / LANES);
      2'b10:   f_beats = CW'(20 / LANES);
      default: f_beats = CW'(BMAX);
    endcase
  endfunction

  logic [0:0]    r_state;
  logic [FW-1:0] r_shift;
  logic [CW-1:0] r_cnt;
  logic [FW-1:0] r_hold_flit;
  logic [CW-1:0] r_hold_beats;
  logic          r_hold_valid;
  logic          r_overrun;

  logic          w_final;
  logic          w_ready;
  logic [CW-1:0] w_beats_in;

  // Last beat of the flit currently on the wire; this is the hand-off point.
  assign w_final    = (r_state == S_SHIFT) && (r_cnt == CW'(1));
  assign w_ready    = !r_hold_valid || w_final;
  assign w_beats_in = f_beats(i_comma_length_sel);

  assign o_serial_out   = (r_state == S_SHIFT) ? r_shift[LANES-1:0] : '0;
  assign o_serial_valid = (r_state == S_SHIFT);
  assign o_done         = w_final;
  assign o_ready        = w_ready;
  assign o_busy         = (r_state == S_SHIFT) || r_hold_valid;
  assign o_overrun      = r_overrun;

  // Shifter, beat counter, holding register and sticky overrun flag.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_shift      <= '0;
      r_cnt        <= '0;
      r_hold_flit  <= '0;
      r_hold_beats <= '0;
      r_hold_valid <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      // A start that finds the hold occupied (and no drain this cycle) is lost.
      if (i_start && !w_ready) begin
        r_overrun <= 1'b1;
      end

      if (r_state == S_IDLE) begin
        if (i_start) begin
          r_shift <= i_enc_flit;
          r_cnt   <= w_beats_in;
          r_state <= S_SHIFT;
        end
      end else if (w_final) begin
        // Held flit has priority so flits leave in arrival order; a start on
        // this same cycle refills the hold as it drains.
        if (r_hold_valid) begin
          r_shift <= r_hold_flit;
          r_cnt   <= r_hold_beats;
          if (i_start) begin
            r_hold_flit  <= i_enc_flit;
            r_hold_beats <= w_beats_in;
          end else begin
            r_hold_valid <= 1'b0;
          end
        end else if (i_start) begin
          r_shift <= i_enc_flit;
          r_cnt   <= w_beats_in;
        end else begin
          r_state <= S_IDLE;
          r_shift <= '0;
          r_cnt   <= '0;
        end
      end else begin
        r_shift <= r_shift >> LANES;
        r_cnt   <= r_cnt - CW'(1);
        if (i_start && !r_hold_valid) begin
          r_hold_flit  <= i_enc_flit;
          r_hold_beats <= w_beats_in;
          r_hold_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/tx_lane_serializer.md
# tx_lane_serializer

Parallel-to-serial stage directly downstream of the TX PHY manager's 8b/10b encoder. Accepts one encoded flit (up to NSYM 10-bit symbols) per `start` pulse and shifts it onto the lane LANES bits per cycle, LSB first, symbol 0 first. A one-entry holding register lets the next flit queue behind the one being shifted. `done` pulses on the last beat of each flit; the arbitration buffer uses it to advance.

## Interface
- NSYM, 4, symbols in a full-length encoded flit (flit width NSYM*10)
- LANES, 2, bits emitted per cycle; must divide 10 (legal: 1, 2, 5, 10)
- CLK  in  1  clock, all state on rising edge
- RST  in  1  reset, asynchronous, active-high
- enc_flit  in  NSYM*10  encoded flit from encoder, symbol k at bits [10k+9:10k]
- start  in  1  one-cycle pulse, enc_flit/comma_length_sel valid this cycle
- comma_length_sel  in  2  00 full (NSYM symbols), 01 one symbol, 10 two symbols, 11 treated as 00
- serial_out  out  LANES  lane data, bit 0 is earliest on the wire
- serial_valid  out  1  serial_out carries flit bits this cycle
- done  out  1  one-cycle pulse coincident with the final beat of a flit
- ready  out  1  holding register empty; a start now is accepted
- busy  out  1  shifter active or holding register full
- overrun  out  1  sticky: start received while not ready; cleared only by RST

## Operation
- Symbol count n: 1, 2 or NSYM per comma_length_sel. Beats per flit B = n*10/LANES.
- Storage: shift register (NSYM*10 bits), beat counter (width clog2(NSYM*10/LANES+1)), holding register (flit + length), hold_valid flag, overrun flag.
- States: IDLE, SHIFT.
- IDLE: serial_valid=0, serial_out=0. On start: load shifter with enc_flit, counter=B, go SHIFT.
- SHIFT: each cycle drive serial_out = shifter[LANES-1:0], serial_valid=1, shift right by LANES, decrement counter.
- Final beat (counter==1): done=1. Next cycle source, in priority order: hold_valid (load from hold, clear hold_valid); else start this cycle (load enc_flit directly); else go IDLE.
- start in SHIFT, not final beat, hold empty: capture into holding register, hold_valid=1.
- start on final beat with hold full: hold drains into shifter, new flit goes into hold; no loss.
- start while hold full and not final beat (ready=0): flit dropped, overrun set, no other state change.
- ready = !hold_valid || (state==SHIFT && counter==1). busy = (state==SHIFT) || hold_valid.
- Bits above n*10 in enc_flit are ignored and never emitted.

## Timing
- Reset values: state IDLE, serial_out=0, serial_valid=0, done=0, ready=1, busy=0, overrun=0, hold empty, counter 0.
- Latency: start at cycle t in IDLE -> first beat at t+1, final beat and done at t+B.
- Back-to-back flits: zero bubble cycles between final beat of one flit and first beat of the next, whether the next comes from hold or from a start on the final-beat cycle.
- done is combinational from the registered state (counter==1 in SHIFT) and is never high when serial_valid is low.
- RST asserted mid-flit: all outputs return to reset values immediately (asynchronous); in-flight and held flits are discarded; no done is issued for them.
- Throughput: one full flit per B cycles sustained.

## Test plan
- Single full flit, NSYM=4, LANES=2, enc_flit=40'hA5_5A5A_5A5A, sel=00 -> serial_valid 20 cycles starting t+1; the 2-bit beats concatenated reproduce 40'hA5_5A5A_5A5A LSB first; done only on beat 20; busy falls the cycle after.
- Comma flit sel=01, enc_flit[9:0]=10'h17C, upper bits 1s -> 5 beats emit 10'h17C, done on beat 5, no upper bits on the wire.
- Three flits (full, sel=10, full) via start at t, t+3, then on the first flit's final-beat cycle -> 20+10+20 contiguous valid beats, three done pulses, overrun=0.
- start while hold full mid-flit -> overrun=1 and stays 1; dropped flit never appears; in-flight and held flits complete normally.
- RST asserted at beat 7 of a full flit with hold full -> next cycle serial_valid=0, ready=1, busy=0, overrun=0; a new start after RST deasserts serializes cleanly in 20 beats.
- sel=11 -> behaves exactly as sel=00 (20 beats).
